// File: rtl/apb_reg_master_arb_if.sv
// APB bus bundle between the register-block master/arbiter and the 16-bit slave.
interface apb_reg_master_arb_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) ();
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA;
    logic [DATA_W-1:0] PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    modport master (
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_reg_master_arb.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// per-requester read data / error status, and abort of stalled accesses.
module apb_reg_master_arb #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    input  logic              req0_valid,
    input  logic              req0_write,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_done,
    output logic [DATA_W-1:0] req0_rdata,
    output logic              req0_err,
    input  logic              req1_valid,
    input  logic              req1_write,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_done,
    output logic [DATA_W-1:0] req1_rdata,
    output logic              req1_err,
    output logic              busy,
    output logic              grant,
    apb_reg_master_arb_if.master apb
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t            state_reg;
    logic              psel_reg;
    logic              penable_reg;
    logic              pwrite_reg;
    logic [ADDR_W-1:0] paddr_reg;
    logic [DATA_W-1:0] pwdata_reg;
    logic [CNT_W-1:0]  wait_cnt_reg;
    logic              grant_reg;
    logic              last_grant_reg;
    logic [1:0]        done_reg;
    logic [1:0]        err_reg;
    logic [DATA_W-1:0] rdata_reg [2];

    logic [1:0] req_valid;
    logic [1:0] eligible;
    logic       pick;

    assign req_valid = {req1_valid, req0_valid};

    // A requester whose done is high this cycle has just finished; its valid
    // still reflects the old request, so it sits out this arbitration round.
    for (genvar gi = 0; gi < 2; gi++) begin : g_elig
        assign eligible[gi] = req_valid[gi] & ~done_reg[gi];
    end

    // req1 wins when it is alone, or when both ask and req0 was served last.
    assign pick = eligible[1] & (~eligible[0] | ~last_grant_reg);

    // Transfer sequencer: arbitration, APB phases, completion and timeout.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg      <= IDLE;
            psel_reg       <= 1'b0;
            penable_reg    <= 1'b0;
            pwrite_reg     <= 1'b0;
            paddr_reg      <= '0;
            pwdata_reg     <= '0;
            wait_cnt_reg   <= '0;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            done_reg       <= '0;
            err_reg        <= '0;
            rdata_reg[0]   <= '0;
            rdata_reg[1]   <= '0;
        end else begin
            done_reg <= '0;
            case (state_reg)
                IDLE: begin
                    if (|eligible) begin
                        state_reg      <= SETUP;
                        psel_reg       <= 1'b1;
                        penable_reg    <= 1'b0;
                        grant_reg      <= pick;
                        last_grant_reg <= pick;
                        pwrite_reg     <= pick ? req1_write : req0_write;
                        paddr_reg      <= pick ? req1_addr  : req0_addr;
                        pwdata_reg     <= pick ? req1_wdata : req0_wdata;
                    end
                end
                SETUP: begin
                    state_reg    <= ACCESS;
                    penable_reg  <= 1'b1;
                    wait_cnt_reg <= '0;
                end
                ACCESS: begin
                    if (apb.PREADY) begin
                        state_reg           <= IDLE;
                        psel_reg            <= 1'b0;
                        penable_reg         <= 1'b0;
                        done_reg[grant_reg] <= 1'b1;
                        err_reg[grant_reg]  <= apb.PSLVERR;
                        if (!pwrite_reg) begin
                            rdata_reg[grant_reg] <= apb.PRDATA;
                        end
                    end else if (wait_cnt_reg == CNT_LAST) begin
                        // Slave stalled too long: give up and flag an error.
                        state_reg           <= IDLE;
                        psel_reg            <= 1'b0;
                        penable_reg         <= 1'b0;
                        done_reg[grant_reg] <= 1'b1;
                        err_reg[grant_reg]  <= 1'b1;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    state_reg   <= IDLE;
                    psel_reg    <= 1'b0;
                    penable_reg <= 1'b0;
                end
            endcase
        end
    end

    assign apb.PSEL    = psel_reg;
    assign apb.PENABLE = penable_reg;
    assign apb.PWRITE  = pwrite_reg;
    assign apb.PADDR   = paddr_reg;
    assign apb.PWDATA  = pwdata_reg;

    assign req0_done  = done_reg[0];
    assign req1_done  = done_reg[1];
    assign req0_err   = err_reg[0];
    assign req1_err   = err_reg[1];
    assign req0_rdata = rdata_reg[0];
    assign req1_rdata = rdata_reg[1];

    assign busy  = (state_reg != IDLE);
    assign grant = grant_reg;
endmodule

// File: tb/tb_apb_reg_master_arb.sv
// Randomized bench for apb_reg_master_arb: a transaction-level model predicts
// grant order, completion cycle and per-requester results every cycle.
module tb_apb_reg_master_arb;
    localparam int ADDR_W   = 8;
    localparam int DATA_W   = 16;
    localparam int TIMEOUT  = 16;
    localparam int N_CYCLES = 3000;

    logic PCLK = 1'b0;
    logic PRESETn = 1'b0;
    always #5 PCLK = ~PCLK;

    logic [1:0]        r_valid;
    logic [1:0]        r_write;
    logic [ADDR_W-1:0] r_addr  [2];
    logic [DATA_W-1:0] r_wdata [2];
    logic              req0_done, req1_done, req0_err, req1_err, busy, grant;
    logic [DATA_W-1:0] req0_rdata, req1_rdata;

    apb_reg_master_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) apb ();

    apb_reg_master_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .req0_valid (r_valid[0]),
        .req0_write (r_write[0]),
        .req0_addr  (r_addr[0]),
        .req0_wdata (r_wdata[0]),
        .req0_done  (req0_done),
        .req0_rdata (req0_rdata),
        .req0_err   (req0_err),
        .req1_valid (r_valid[1]),
        .req1_write (r_write[1]),
        .req1_addr  (r_addr[1]),
        .req1_wdata (r_wdata[1]),
        .req1_done  (req1_done),
        .req1_rdata (req1_rdata),
        .req1_err   (req1_err),
        .busy       (busy),
        .grant      (grant),
        .apb        (apb)
    );

    // Reference model: one transfer in flight, described by its grant edge,
    // its completion edge and its outcome.
    int                cyc;
    bit                m_active;
    int                m_grant_edge;
    int                m_end_edge;
    bit                m_owner;
    bit                m_to;
    bit                m_last;
    int                m_wait;
    bit [1:0]          e_done;
    bit [1:0]          e_err;
    logic [DATA_W-1:0] e_rdata [2];
    bit                e_grant, e_psel, e_penable, e_pwrite;
    logic [ADDR_W-1:0] e_paddr;
    logic [DATA_W-1:0] e_pwdata;

    int n_errs   = 0;
    int n_checks = 0;
    int n_xfers  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_active   = 1'b0;
        m_last     = 1'b1;
        e_done     = '0;
        e_err      = '0;
        e_rdata[0] = '0;
        e_rdata[1] = '0;
        e_grant    = 1'b0;
        e_psel     = 1'b0;
        e_penable  = 1'b0;
        e_pwrite   = 1'b0;
        e_paddr    = '0;
        e_pwdata   = '0;
    endtask

    // Advance the model across the clock edge just taken, using the inputs
    // that were present at that edge.
    task automatic model_edge();
        bit [1:0] prev_done;
        bit [1:0] elig;
        bit       pick;
        prev_done = e_done;
        e_done    = '0;
        if (m_active) begin
            if (cyc == m_end_edge) begin
                e_done[m_owner] = 1'b1;
                if (m_to) begin
                    e_err[m_owner] = 1'b1;
                end else begin
                    e_err[m_owner] = apb.PSLVERR;
                    if (!e_pwrite) e_rdata[m_owner] = apb.PRDATA;
                end
                m_active  = 1'b0;
                e_psel    = 1'b0;
                e_penable = 1'b0;
                n_xfers++;
                $display("xfer %0d: req%0d %s addr=%02h wdata=%04h wait=%0d timeout=%0d err=%0d rdata=%04h",
                         n_xfers, m_owner, e_pwrite ? "WR" : "RD", e_paddr, e_pwdata,
                         m_to ? TIMEOUT : m_wait, m_to, e_err[m_owner], e_rdata[m_owner]);
            end else begin
                e_penable = 1'b1;
            end
        end else begin
            elig[0] = r_valid[0] && !prev_done[0];
            elig[1] = r_valid[1] && !prev_done[1];
            if (elig != 2'b00) begin
                if (elig == 2'b11) pick = !m_last;
                else               pick = elig[1];
                m_owner      = pick;
                m_last       = pick;
                m_active     = 1'b1;
                m_grant_edge = cyc;
                e_grant      = pick;
                e_pwrite     = r_write[pick];
                e_paddr      = r_addr[pick];
                e_pwdata     = r_wdata[pick];
                m_to         = ($urandom_range(0, 7) == 0);
                m_wait       = $urandom_range(0, 4);
                m_end_edge   = m_to ? cyc + 1 + TIMEOUT : cyc + 2 + m_wait;
                e_psel       = 1'b1;
                e_penable    = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        check("psel",    apb.PSEL,    e_psel);
        check("penable", apb.PENABLE, e_penable);
        check("pwrite",  apb.PWRITE,  e_pwrite);
        check("paddr",   apb.PADDR,   e_paddr);
        check("pwdata",  apb.PWDATA,  e_pwdata);
        check("busy",    busy,        m_active);
        check("grant",   grant,       e_grant);
        check("done0",   req0_done,   e_done[0]);
        check("done1",   req1_done,   e_done[1]);
        check("err0",    req0_err,    e_err[0]);
        check("err1",    req1_err,    e_err[1]);
        check("rdata0",  req0_rdata,  e_rdata[0]);
        check("rdata1",  req1_rdata,  e_rdata[1]);
    endtask

    // Slave: exact PREADY schedule during ACCESS, noise on every other cycle.
    task automatic drive_slave();
        bit in_access;
        in_access   = m_active && (cyc > m_grant_edge);
        apb.PREADY  = in_access ? (!m_to && (cyc + 1 == m_end_edge)) : 1'($urandom_range(0, 1));
        apb.PRDATA  = DATA_W'($urandom);
        apb.PSLVERR = 1'($urandom_range(0, 1));
    endtask

    // Requesters hold a request until its done, then may immediately ask again.
    task automatic drive_req();
        for (int i = 0; i < 2; i++) begin
            if (!r_valid[i] || e_done[i]) begin
                if ($urandom_range(0, 3) != 0) begin
                    r_valid[i] = 1'b1;
                    r_write[i] = 1'($urandom_range(0, 1));
                    r_addr[i]  = ADDR_W'($urandom);
                    r_wdata[i] = DATA_W'($urandom);
                end else begin
                    r_valid[i] = 1'b0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge PCLK);
        #1;
        cyc++;
        model_edge();
        compare_all();
        drive_slave();
        drive_req();
    endtask

    task automatic load_both_valid();
        r_valid    = 2'b11;
        r_write    = 2'b10;
        r_addr[0]  = 8'h0C;
        r_wdata[0] = 16'h1234;
        r_addr[1]  = 8'h20;
        r_wdata[1] = 16'hBEEF;
    endtask

    initial begin
        bit found;
        cyc = 0;
        model_reset();
        load_both_valid();
        apb.PREADY  = 1'b0;
        apb.PRDATA  = '0;
        apb.PSLVERR = 1'b0;

        repeat (3) @(posedge PCLK);
        #1;
        compare_all();

        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int k = 0; k < N_CYCLES; k++) step();

        // Find a cycle inside ACCESS with at least one more ACCESS cycle to go.
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            step();
            if (m_active && (cyc > m_grant_edge) && (cyc + 1 < m_end_edge)) found = 1'b1;
        end
        check("reach_access", found, 1'b1);

        #2;
        PRESETn = 1'b0;
        #1;
        check("rst_psel",    apb.PSEL,    1'b0);
        check("rst_penable", apb.PENABLE, 1'b0);
        check("rst_busy",    busy,        1'b0);
        check("rst_done0",   req0_done,   1'b0);
        check("rst_done1",   req1_done,   1'b0);
        model_reset();
        load_both_valid();
        @(posedge PCLK);
        #1;
        compare_all();

        @(negedge PCLK);
        PRESETn = 1'b1;
        for (int k = 0; k < 400; k++) step();

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule
